// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte buffer between the UART receiver and the host
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int AF_THRESH    = 12
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  input  logic                    rx_break,
  input  logic                    flush,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [PAYLOAD_BITS-1:0] m_data,
  output logic                    m_break,
  output logic [DEPTH_LOG2:0]     level,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_AF   = (DEPTH_LOG2+1)'(AF_THRESH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [PAYLOAD_BITS:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic [PAYLOAD_BITS:0]   head;

  // Flags decode the registered level only, so no input reaches them combinationally.
  assign empty       = (level == '0);
  assign full        = (level == LVL_FULL);
  assign almost_full = (level >= LVL_AF);
  assign m_valid     = !empty;

  assign pop  = m_valid && m_ready && !flush;
  assign push = rx_valid && (!full || pop) && !flush;
  assign drop = rx_valid && full && !pop && !flush;

  assign head    = mem[rd_ptr];
  assign m_data  = head[PAYLOAD_BITS-1:0];
  assign m_break = head[PAYLOAD_BITS];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {rx_break, rx_data};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !push) begin
        level <= level - LVL_ONE;
      end
    end
  end

  // A drop and a clear in the same cycle leave the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       flush;
  logic       m_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_break;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overrun;
  logic       clr_overrun;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .flush(flush), .m_ready(m_ready), .m_valid(m_valid),
    .m_data(m_data), .m_break(m_break), .level(level), .empty(empty),
    .full(full), .almost_full(almost_full), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic brk, input logic [7:0] d, input bit accepted);
    rx_valid = 1'b1;
    rx_break = brk;
    rx_data  = d;
    if (accepted) sb.push_back({brk, d});
    tick();
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  task automatic check_head(input string tag);
    logic [8:0] exp;
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_head"}, 32'({m_break, m_data}), 32'(exp));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = sb.size();
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check_head(tag);
      tick();
    end
    m_ready = 1'b0;
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_mvalid_low"}, 32'(m_valid), 32'd0);
    chk({tag, "_level0"}, 32'(level), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_break = 1'b0;
    flush = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: two words, head visible one cycle after first strobe
    push_word(1'b0, 8'hA5, 1'b1);
    chk("t1_latency_valid", 32'(m_valid), 32'd1);
    chk("t1_latency_data", 32'(m_data), 32'hA5);
    push_word(1'b0, 8'h3C, 1'b1);
    chk("t1_level", 32'(level), 32'd2);

    // 2: held m_ready drains in order
    drain("t2");

    // 3: fill to full, overflow drops 0xFF
    for (int i = 0; i < 16; i++) begin
      push_word(1'b0, 8'(i), 1'b1);
      chk("t3_af", 32'(almost_full), 32'(i + 1 >= 12));
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_level", 32'(level), 32'd16);
    push_word(1'b0, 8'hFF, 1'b0);
    chk("t3_overrun", 32'(overrun), 32'd1);
    chk("t3_level_after_drop", 32'(level), 32'd16);
    drain("t3");
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    chk("t3_clr", 32'(overrun), 32'd0);

    // 4: full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_word(1'b0, 8'(8'h10 + i), 1'b1);
    m_ready = 1'b1;
    check_head("t4_pop");
    push_word(1'b0, 8'h77, 1'b1);
    m_ready = 1'b0;
    chk("t4_level", 32'(level), 32'd16);
    chk("t4_overrun", 32'(overrun), 32'd0);
    drain("t4");

    // 5: BREAK word ordering
    push_word(1'b1, 8'h00, 1'b1);
    push_word(1'b0, 8'h41, 1'b1);
    drain("t5");

    // empty with m_ready: pointers must not move
    m_ready = 1'b1; tick(); tick(); m_ready = 1'b0;
    chk("empty_pop_level", 32'(level), 32'd0);
    push_word(1'b0, 8'h5A, 1'b1);
    chk("empty_pop_level1", 32'(level), 32'd1);
    drain("empty_pop");

    // 6b: overflow together with clr_overrun, set wins
    for (int i = 0; i < 16; i++) push_word(1'b0, 8'(8'h80 + i), 1'b1);
    clr_overrun = 1'b1;
    push_word(1'b0, 8'hEE, 1'b0);
    clr_overrun = 1'b0;
    chk("t6_set_wins", 32'(overrun), 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    sb.delete();
    chk("t6_flush_full_level", 32'(level), 32'd0);

    // 6: flush with concurrent push and pop
    for (int i = 0; i < 5; i++) push_word(1'b0, 8'(8'h20 + i), 1'b1);
    chk("t6_level5", 32'(level), 32'd5);
    flush = 1'b1; m_ready = 1'b1;
    push_word(1'b0, 8'h55, 1'b0);
    flush = 1'b0; m_ready = 1'b0;
    sb.delete();
    chk("t6_flush_level", 32'(level), 32'd0);
    chk("t6_flush_mvalid", 32'(m_valid), 32'd0);
    chk("t6_flush_overrun", 32'(overrun), 32'd1);
    push_word(1'b0, 8'h66, 1'b1);
    chk("t6_post_level", 32'(level), 32'd1);
    drain("t6_post");
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    chk("t6_clr", 32'(overrun), 32'd0);

    // mid-operation async reset
    push_word(1'b0, 8'h99, 1'b0);
    chk("ar_pre_valid", 32'(m_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_mvalid", 32'(m_valid), 32'd0);
    chk("ar_level", 32'(level), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
